// File: rtl/serial_rx_fifo.sv
// serial_rx_fifo: 8N1 serial receiver sampling at N clocks per bit, feeding a
// small first-word-fall-through FIFO. Framing errors and dropped bytes are
// reported as single-cycle pulses.
module serial_rx_fifo #(
    parameter int DEPTH = 4,
    parameter int N     = 16
) (
    input  logic       CLK_RX,
    input  logic       RST,
    input  logic       RX,
    input  logic       RD_EN,
    output logic [7:0] DATA,
    output logic       EMPTY,
    output logic       FULL,
    output logic       OVERRUN,
    output logic       FRAME_ERR
);

    localparam int AW   = $clog2(DEPTH);
    localparam int CW   = $clog2(10 * N);
    localparam int HALF = N / 2 - 1;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_START,
        ST_DATA,
        ST_STOP,
        ST_BREAK
    } state_t;

    // ---------------------------------------------------------------
    // Line synchronizer and edge detect
    // ---------------------------------------------------------------
    logic sync0, line, line_d;
    logic start_edge;

    // Two-flop synchronizer plus one delayed copy for falling-edge detection
    always_ff @(posedge CLK_RX or posedge RST) begin
        if (RST) begin
            sync0  <= 1'b1;
            line   <= 1'b1;
            line_d <= 1'b1;
        end else begin
            sync0  <= RX;
            line   <= sync0;
            line_d <= line;
        end
    end

    assign start_edge = line_d & ~line;

    // ---------------------------------------------------------------
    // Receiver FSM
    // ---------------------------------------------------------------
    state_t         state;
    logic [CW-1:0]  cnt;      // ticks since start-edge detection
    logic [CW-1:0]  smp_at;   // tick of the next mid-bit sample
    logic [2:0]     bit_idx;
    logic [7:0]     shreg;
    logic           frame_err;
    logic           at_smp;
    logic           wr_req;
    logic [7:0]     wr_byte;

    assign at_smp  = (cnt == smp_at);
    // Stop sample high completes a good byte; the FIFO takes it at this same edge
    assign wr_req  = (state == ST_STOP) && at_smp && line;
    assign wr_byte = shreg;

    // Frame sequencing: one frame-wide tick counter, sample point advances by N
    always_ff @(posedge CLK_RX or posedge RST) begin
        if (RST) begin
            state     <= ST_IDLE;
            cnt       <= '0;
            smp_at    <= '0;
            bit_idx   <= '0;
            shreg     <= '0;
            frame_err <= 1'b0;
        end else begin
            frame_err <= 1'b0;
            cnt       <= cnt + 1'b1;
            case (state)
                ST_IDLE: begin
                    cnt <= '0;
                    if (start_edge) begin
                        state   <= ST_START;
                        smp_at  <= CW'(HALF);
                        bit_idx <= '0;
                    end
                end
                ST_START: begin
                    if (at_smp) begin
                        if (line) begin
                            // Too short to be a start bit
                            state <= ST_IDLE;
                        end else begin
                            state  <= ST_DATA;
                            smp_at <= smp_at + CW'(N);
                        end
                    end
                end
                ST_DATA: begin
                    if (at_smp) begin
                        shreg  <= {line, shreg[7:1]};
                        smp_at <= smp_at + CW'(N);
                        if (bit_idx == 3'd7) begin
                            state <= ST_STOP;
                        end else begin
                            bit_idx <= bit_idx + 1'b1;
                        end
                    end
                end
                ST_STOP: begin
                    if (at_smp) begin
                        if (line) begin
                            // Back to IDLE mid stop bit so an early next start is caught
                            state <= ST_IDLE;
                        end else begin
                            frame_err <= 1'b1;
                            state     <= ST_BREAK;
                        end
                    end
                end
                ST_BREAK: begin
                    // Wait out a held-low line; no start detection in here
                    cnt <= '0;
                    if (line) begin
                        state <= ST_IDLE;
                    end
                end
                default: begin
                    state <= ST_IDLE;
                    cnt   <= '0;
                end
            endcase
        end
    end

    assign FRAME_ERR = frame_err;

    // ---------------------------------------------------------------
    // FIFO
    // ---------------------------------------------------------------
    logic [7:0]  mem [DEPTH];
    logic [AW:0] wr_ptr, rd_ptr;
    logic [AW:0] wr_next, rd_next;
    logic        pop, wr_ok;
    logic [7:0]  data_q;
    logic        overrun;

    assign EMPTY   = (wr_ptr == rd_ptr);
    assign FULL    = (wr_ptr[AW] != rd_ptr[AW]) &&
                     (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign pop     = RD_EN & ~EMPTY;
    // A pop at the same edge frees the slot, so a write to a full FIFO still lands
    assign wr_ok   = wr_req & (~FULL | pop);
    assign rd_next = pop   ? rd_ptr + 1'b1 : rd_ptr;
    assign wr_next = wr_ok ? wr_ptr + 1'b1 : wr_ptr;

    // Storage array, no reset needed: contents are only read behind the pointers
    always_ff @(posedge CLK_RX) begin
        if (wr_ok) begin
            mem[wr_ptr[AW-1:0]] <= wr_byte;
        end
    end

    // Pointers, overrun pulse and registered head byte
    always_ff @(posedge CLK_RX or posedge RST) begin
        if (RST) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            data_q  <= 8'h00;
            overrun <= 1'b0;
        end else begin
            overrun <= wr_req & FULL & ~pop;
            wr_ptr  <= wr_next;
            rd_ptr  <= rd_next;
            // Preload the next head; if it is the slot written right now, bypass
            if (rd_next != wr_next) begin
                if (rd_next == wr_ptr) begin
                    data_q <= wr_byte;
                end else begin
                    data_q <= mem[rd_next[AW-1:0]];
                end
            end
        end
    end

    assign DATA    = data_q;
    assign OVERRUN = overrun;

endmodule
